// File: rtl/serv_rf_ram_bridge.sv
// Bridge between SERV's bit-serial register-file ports and a WIDTH-bit simple-dual-port RAM.
// Optional macro SERV_RF_BRIDGE_ZERO_X0_EN hard-wires x0: writes to it are dropped, reads return zero.
module serv_rf_ram_bridge #(
    parameter int WIDTH    = 2,
    parameter int WITH_CSR = 1,
    parameter int DEPTH_W  = 5 + WITH_CSR + $clog2(32 / WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rreq,
    output logic                  o_ready,
    input  logic [4+WITH_CSR:0]   i_rreg0,
    input  logic [4+WITH_CSR:0]   i_rreg1,
    output logic                  o_rdata0,
    output logic                  o_rdata1,
    input  logic [4+WITH_CSR:0]   i_wreg0,
    input  logic [4+WITH_CSR:0]   i_wreg1,
    input  logic                  i_wen0,
    input  logic                  i_wen1,
    input  logic                  i_wdata0,
    input  logic                  i_wdata1,
    output logic [DEPTH_W-1:0]    o_waddr,
    output logic [WIDTH-1:0]      o_wdata,
    output logic                  o_wen,
    output logic [DEPTH_W-1:0]    o_raddr,
    output logic                  o_ren,
    input  logic [WIDTH-1:0]      i_rdata
);
    localparam int RW  = 5 + WITH_CSR;
    localparam int WB  = $clog2(WIDTH);
    localparam int NWB = 5 - WB;
    localparam logic [WB-1:0] PH_ONE  = WB'(1);
    localparam logic [WB-1:0] PH_LAST = WB'(WIDTH - 1);
    localparam logic [WB-1:0] PH_LOAD = WB'(2 % WIDTH);
    localparam logic [5:0]    LAST_LD = 6'(34 - WIDTH);

    typedef enum logic {IDLE, READ} state_t;

    state_t           state_q, state_d;
    logic [5:0]       rcnt_q, rcnt_d;
    logic [RW-1:0]    rreg0_q, rreg0_d, rreg1_q, rreg1_d;
    logic [WIDTH-1:0] stage0_q, stage0_d, sreg0_q, sreg0_d, sreg1_q, sreg1_d;
    logic [5:0]       cyc;
    logic [WB-1:0]    phase;
    logic [4:0]       rword;
    logic [RW-1:0]    rsel;
    logic             rd_load, rd_bits, zero0, zero1;

    // cyc is the offset from the request cycle; fetch, staging and output all key off it
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        rreg0_d  = rreg0_q;
        rreg1_d  = rreg1_q;
        stage0_d = stage0_q;
        sreg0_d  = sreg0_q;
        sreg1_d  = sreg1_q;
        cyc      = (state_q == READ) ? rcnt_q : 6'd0;
        phase    = cyc[WB-1:0];
        rword    = cyc[4:0] >> WB;
        rd_load  = (state_q == READ) && (cyc >= 6'd2) && (cyc <= LAST_LD) && (phase == PH_LOAD);
        rd_bits  = (state_q == READ) && (cyc >= 6'd2);
        o_ren    = ((state_q == IDLE) && i_rreq) ||
                   ((state_q == READ) && (cyc < 6'd32) && (phase <= PH_ONE));
        rsel     = (state_q == IDLE) ? i_rreg0 : (phase[0] ? rreg1_q : rreg0_q);
        o_raddr  = o_ren ? ((DEPTH_W'(rsel) << NWB) | DEPTH_W'(rword)) : '0;
        o_ready  = (state_q == READ) && (cyc == 6'd2);
`ifdef SERV_RF_BRIDGE_ZERO_X0_EN
        zero0    = (rreg0_q == '0);
        zero1    = (rreg1_q == '0);
`else
        zero0    = 1'b0;
        zero1    = 1'b0;
`endif
        o_rdata0 = rd_bits && !zero0 && (rd_load ? stage0_q[0] : sreg0_q[0]);
        o_rdata1 = rd_bits && !zero1 && (rd_load ? i_rdata[0] : sreg1_q[0]);
        case (state_q)
            IDLE: begin
                if (i_rreq) begin
                    state_d = READ;
                    rcnt_d  = 6'd1;
                    rreg0_d = i_rreg0;
                    rreg1_d = i_rreg1;
                end
            end
            READ: begin
                rcnt_d = rcnt_q + 6'd1;
                if (phase == PH_ONE) stage0_d = i_rdata;
                if (rd_load) begin
                    sreg0_d = stage0_q >> 1;
                    sreg1_d = i_rdata >> 1;
                end else begin
                    sreg0_d = sreg0_q >> 1;
                    sreg1_d = sreg1_q >> 1;
                end
                if (rcnt_q == 6'd33) begin
                    state_d = IDLE;
                    rcnt_d  = 6'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rcnt_q   <= '0;
            rreg0_q  <= '0;
            rreg1_q  <= '0;
            stage0_q <= '0;
            sreg0_q  <= '0;
            sreg1_q  <= '0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            rreg0_q  <= rreg0_d;
            rreg1_q  <= rreg1_d;
            stage0_q <= stage0_d;
            sreg0_q  <= sreg0_d;
            sreg1_q  <= sreg1_d;
        end
    end

    logic [4:0]         bcnt_q [2];
    logic [4:0]         bcnt_d [2];
    logic [WIDTH-1:0]   wbuf_q [2];
    logic [WIDTH-1:0]   wbuf_d [2];
    logic [WIDTH-1:0]   wword  [2];
    logic [RW-1:0]      wreg   [2];
    logic [DEPTH_W-1:0] wadr   [2];
    logic               wen_in [2];
    logic               wbit   [2];
    logic               wdone  [2];
    logic               wen_q, wen_d, pend_q, pend_d;
    logic [DEPTH_W-1:0] waddr_q, waddr_d, pend_addr_q, pend_addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d, pend_data_q, pend_data_d;

    // bcnt is the bit index within the register: low WB bits pick the slot, the rest is the word
    always_comb begin
        wreg[0]   = i_wreg0;
        wreg[1]   = i_wreg1;
        wen_in[0] = i_wen0;
        wen_in[1] = i_wen1;
        wbit[0]   = i_wdata0;
        wbit[1]   = i_wdata1;
        for (int p = 0; p < 2; p++) begin
            wword[p] = wbuf_q[p];
            wword[p][bcnt_q[p][WB-1:0]] = wbit[p];
            wdone[p] = wen_in[p] && (bcnt_q[p][WB-1:0] == PH_LAST);
`ifdef SERV_RF_BRIDGE_ZERO_X0_EN
            if (wreg[p] == '0) wdone[p] = 1'b0;
`endif
            wadr[p]   = (DEPTH_W'(wreg[p]) << NWB) | DEPTH_W'(bcnt_q[p] >> WB);
            bcnt_d[p] = wen_in[p] ? bcnt_q[p] + 5'd1 : bcnt_q[p];
            wbuf_d[p] = wen_in[p] ? wword[p] : wbuf_q[p];
        end
    end

    // Port 1 loses a tie and is replayed next cycle; WIDTH >= 2 keeps that slot free
    always_comb begin
        wen_d       = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        pend_d      = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        if (pend_q) begin
            wen_d   = 1'b1;
            waddr_d = pend_addr_q;
            wdata_d = pend_data_q;
        end else if (wdone[0]) begin
            wen_d   = 1'b1;
            waddr_d = wadr[0];
            wdata_d = wword[0];
            if (wdone[1]) begin
                pend_d      = 1'b1;
                pend_addr_d = wadr[1];
                pend_data_d = wword[1];
            end
        end else if (wdone[1]) begin
            wen_d   = 1'b1;
            waddr_d = wadr[1];
            wdata_d = wword[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int p = 0; p < 2; p++) begin
                bcnt_q[p] <= '0;
                wbuf_q[p] <= '0;
            end
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                bcnt_q[p] <= bcnt_d[p];
                wbuf_q[p] <= wbuf_d[p];
            end
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign o_wen   = wen_q;
    assign o_waddr = waddr_q;
    assign o_wdata = wdata_q;

endmodule
